// File: rtl/uart_echo_checker_pkg.sv
// Shared types and pattern helpers for the UART echo checker.
package uart_echo_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_INCR  = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_WALK  = 2'd3
  } mode_e;

  // Feedback taps for x^8+x^6+x^5+x^4+1 in a left-shifting Fibonacci LFSR.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
  localparam logic [7:0] WALK_INIT = 8'h01;

  function automatic logic [7:0] first_pattern(input mode_e m, input logic [7:0] seed);
    return (m == MODE_WALK) ? WALK_INIT : seed;
  endfunction

  function automatic logic [7:0] next_pattern(input mode_e m, input logic [7:0] cur);
    logic [7:0] nxt;
    nxt = cur;
    case (m)
      MODE_INCR: nxt = cur + 8'd1;
      MODE_LFSR: nxt = {cur[6:0], ^(cur & LFSR_TAPS)};
      MODE_WALK: nxt = {cur[6:0], cur[7]};
      default:   nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/uart_echo_checker_sync_fifo.sv
// Synchronous FIFO holding the bytes still awaiting their echo.
// DEPTH must be a power of two (>=2); push and pop may occur in the same cycle.
module uart_echo_checker_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // NOTE: storage is not reset; only pointers and count need a defined value.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_checker.sv
// Self-checking UART echo traffic generator: sends a patterned byte stream, checks
// every echoed byte against the expected FIFO, reports errors and idle timeouts.
module uart_echo_checker
  import uart_echo_checker_pkg::*;
#(
  parameter int unsigned NUM_BYTES       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1_000_000,
  parameter logic [7:0]  SEED            = 8'h7A,
  localparam int unsigned CW             = $clog2(NUM_BYTES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [CW-1:0] rx_count,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] first_err_index,
  output logic [7:0]    first_err_data
);

  localparam int unsigned   TW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] NUM_C      = CW'(NUM_BYTES);

  state_e        state_q;
  mode_e         mode_q;
  logic [7:0]    pat_q;
  logic [CW-1:0] sent_q, rx_count_q, err_count_q, first_err_index_q;
  logic [7:0]    first_err_data_q;
  logic          timeout_q;
  logic [TW-1:0] timer_q;

  logic       run, start_ok, tx_fire, rx_fire, mismatch, last_rx, expire;
  logic       fifo_full, fifo_empty, fifo_pop;
  logic [7:0] fifo_rdata;

  assign run      = (state_q == ST_RUN);
  assign start_ok = start && !run;
  assign tx_fire  = tx_valid && tx_ready;
  assign rx_fire  = run && rx_valid;
  assign fifo_pop = rx_fire && !fifo_empty;
  assign mismatch = fifo_empty || (rx_data != fifo_rdata);
  assign last_rx  = rx_fire && (rx_count_q == NUM_C - 1'b1);
  assign expire   = run && !tx_fire && !rx_fire && (timer_q == TIMER_LAST);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    if (run && (sent_q != NUM_C) && !fifo_full) begin
      tx_valid = 1'b1;
      tx_data  = pat_q;
    end
  end

  uart_echo_checker_sync_fifo #(
    .WIDTH (8),
    .DEPTH (MAX_OUTSTANDING)
  ) u_expected_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .push  (tx_fire),
    .wdata (tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      mode_q            <= MODE_CONST;
      pat_q             <= SEED;
      sent_q            <= '0;
      rx_count_q        <= '0;
      err_count_q       <= '0;
      first_err_index_q <= '0;
      first_err_data_q  <= 8'h00;
      timeout_q         <= 1'b0;
      timer_q           <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (tx_fire) begin
            pat_q  <= next_pattern(mode_q, pat_q);
            sent_q <= sent_q + 1'b1;
          end
          timer_q <= (tx_fire || rx_fire) ? '0 : timer_q + 1'b1;
          if (rx_fire && rx_count_q != NUM_C) begin
            rx_count_q <= rx_count_q + 1'b1;
            if (mismatch) begin
              err_count_q <= err_count_q + 1'b1;
              if (err_count_q == '0) begin
                first_err_index_q <= rx_count_q;
                first_err_data_q  <= rx_data;
              end
            end
          end
          // A run-completing byte takes priority over an expiring timer.
          if (last_rx) begin
            state_q <= ST_DONE;
          end else if (expire) begin
            state_q   <= ST_DONE;
            timeout_q <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            state_q           <= ST_RUN;
            mode_q            <= mode_e'(mode);
            pat_q             <= first_pattern(mode_e'(mode), SEED);
            sent_q            <= '0;
            rx_count_q        <= '0;
            err_count_q       <= '0;
            first_err_index_q <= '0;
            first_err_data_q  <= 8'h00;
            timeout_q         <= 1'b0;
            timer_q           <= '0;
          end
        end
      endcase
    end
  end

  assign rx_ready        = 1'b1;
  assign busy            = run;
  assign done            = (state_q == ST_DONE);
  assign pass            = done && !timeout_q && (err_count_q == '0);
  assign timeout         = timeout_q;
  assign rx_count        = rx_count_q;
  assign err_count       = err_count_q;
  assign first_err_index = first_err_index_q;
  assign first_err_data  = first_err_data_q;

endmodule
